// File: rtl/scan_pkg.sv
// Shared constants and state encoding for the digit scan transmitter.
package scan_pkg;

    localparam int unsigned NDIG = 9;
    localparam int unsigned DW   = 5;
    localparam int unsigned IDXW = 4;

    // Code sent in place of a suppressed leading zero.
    localparam logic [DW-1:0] BLANK = '1;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        SEND,
        GAP
    } state_e;

endpackage

// File: rtl/digit_scan_tx_if.sv
// Digit scan port bundle.
// The master side is the transmitter; the slave side is the counter and pin mapping.
interface digit_scan_tx_if #(
    parameter int unsigned NDIG = scan_pkg::NDIG,
    parameter int unsigned DW   = scan_pkg::DW,
    parameter int unsigned IDXW = scan_pkg::IDXW
);

    logic [NDIG*DW-1:0] digits_i;
    logic               start_i;
    logic               ready_i;
    logic [DW-1:0]      dig_o;
    logic [IDXW-1:0]    idx_o;
    logic               vld_o;
    logic               sof_o;
    logic               eof_o;
    logic               busy_o;

    modport master (
        input  digits_i, start_i, ready_i,
        output dig_o, idx_o, vld_o, sof_o, eof_o, busy_o
    );

    modport slave (
        output digits_i, start_i, ready_i,
        input  dig_o, idx_o, vld_o, sof_o, eof_o, busy_o
    );

endinterface

// File: rtl/digit_blank.sv
// Leading-zero mask over a packed digit word.
// Used only when LEAD_ZERO_BLANK_EN is defined.
// Digit 0 is never blanked. A digit counts as zero when its low 4 bits are 0.
module digit_blank
    import scan_pkg::*;
#(
    parameter int unsigned NDIG = scan_pkg::NDIG,
    parameter int unsigned DW   = scan_pkg::DW
) (
    input  logic [NDIG*DW-1:0] shadow_i,
    output logic [NDIG-1:0]    blank_o
);

    logic        run;
    int unsigned pos;

    // Walk from the MSD down; the run breaks at the first non-zero digit.
    always_comb begin
        blank_o = '0;
        run     = 1'b1;
        pos     = 0;
        for (int unsigned k = 0; k < NDIG - 1; k++) begin
            pos          = NDIG - 1 - k;
            run          = run & (shadow_i[pos*DW +: 4] == 4'h0);
            blank_o[pos] = run;
        end
    end

endmodule

// File: rtl/digit_scan_tx.sv
// Digit scan transmitter.
// Snapshots the packed digit bus and sends one digit per valid/ready transfer.
// Digits go out most-significant first.
// Optional macro LEAD_ZERO_BLANK_EN replaces leading zero digits with BLANK.
module digit_scan_tx
    import scan_pkg::*;
#(
    parameter int unsigned NDIG = scan_pkg::NDIG,
    parameter int unsigned DW   = scan_pkg::DW,
    parameter int unsigned GAP  = 2,
    parameter int unsigned AUTO = 0
) (
    input logic             CLK,
    input logic             RST,
    digit_scan_tx_if.master bus
);

    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    // The GAP parameter hides the imported enum literal, so the state is package-qualified.
    state_e             state_q, state_d;
    logic [NDIG*DW-1:0] shadow_q, shadow_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [DW-1:0]      dig_q, dig_d;
    logic [IDXW-1:0]    idxo_q, idxo_d;
    logic               vld_q, vld_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic               busy_q, busy_d;
    logic [NDIG-1:0]    blank;

`ifdef LEAD_ZERO_BLANK_EN
    // The mask sees the value the shadow register is about to hold,
    // so the registered first digit is already blanked.
    digit_blank #(.NDIG(NDIG), .DW(DW)) u_blank (
        .shadow_i (shadow_d),
        .blank_o  (blank)
    );
`else
    assign blank = '0;
`endif

    // Frame sequencing: snapshot, send with optional gaps, then idle or re-snapshot.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = SNAP;
            end
            SNAP: begin
                shadow_d = bus.digits_i;
                idx_d    = IDXW'(NDIG - 1);
                state_d  = SEND;
            end
            SEND: begin
                if (bus.ready_i) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - 1'b1;
                        if (GAP > 0) begin
                            state_d = scan_pkg::GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        state_d = (AUTO != 0) ? SNAP : IDLE;
                    end
                end
            end
            scan_pkg::GAP: begin
                if (gap_q == GW'(GAP - 1)) state_d = SEND;
                else                       gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they leave directly from flops.
    always_comb begin
        dig_d  = '0;
        idxo_d = '0;
        vld_d  = 1'b0;
        sof_d  = 1'b0;
        eof_d  = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_d == SEND) begin
            vld_d  = 1'b1;
            idxo_d = idx_d;
            sof_d  = (idx_d == IDXW'(NDIG - 1));
            eof_d  = (idx_d == '0);
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (idx_d == IDXW'(i)) dig_d = blank[i] ? BLANK : shadow_d[i*DW +: DW];
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            dig_q    <= '0;
            idxo_q   <= '0;
            vld_q    <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            dig_q    <= dig_d;
            idxo_q   <= idxo_d;
            vld_q    <= vld_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.dig_o  = dig_q;
    assign bus.idx_o  = idxo_q;
    assign bus.vld_o  = vld_q;
    assign bus.sof_o  = sof_q;
    assign bus.eof_o  = eof_q;
    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_digit_scan_tx.sv
// Self-checking bench for digit_scan_tx.
// It builds two instances: GAP=2/AUTO=0 and GAP=0/AUTO=1.
// It honours LEAD_ZERO_BLANK_EN when the macro is defined.
module tb_digit_scan_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    digit_scan_tx_if b0 ();
    digit_scan_tx_if b1 ();

    digit_scan_tx #(.GAP(2), .AUTO(0)) dut  (.CLK(clk), .RST(rst), .bus(b0.master));
    digit_scan_tx #(.GAP(0), .AUTO(1)) dut2 (.CLK(clk), .RST(rst), .bus(b1.master));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [44:0] pack(input int d[9]);
        logic [44:0] v = '0;
        for (int p = 0; p < 9; p++) v[(8-p)*5 +: 5] = d[p][4:0];
        return v;
    endfunction

    // Expected value of the j-th digit sent in a frame (j=0 is the MSD).
    function automatic logic [4:0] exp_digit(input logic [44:0] v, input int j);
        int pos = 8 - j;
`ifdef LEAD_ZERO_BLANK_EN
        bit z = 1'b1;
        if (pos > 0) begin
            for (int p = 8; p >= pos; p--) if (v[p*5 +: 4] != 4'h0) z = 1'b0;
            if (z) return 5'h1F;
        end
`endif
        return v[pos*5 +: 5];
    endfunction

    // ---------------- behavioural model: a frame is a list of nine digits ----------------
    logic [4:0] mf [2][9];
    int         ms [2]     = '{0, 0};
    int         mw [2]     = '{0, 0};
    bit         mact [2]   = '{0, 0};
    bit         msnap [2]  = '{0, 0};
    int         gapk [2]   = '{2, 0};
    bit         autok [2]  = '{0, 1};

    always @(posedge clk or posedge rst) begin
        logic [44:0] dv;
        bit st, rd;
        for (int k = 0; k < 2; k++) begin
            dv = (k == 0) ? b0.digits_i : b1.digits_i;
            st = (k == 0) ? b0.start_i  : b1.start_i;
            rd = (k == 0) ? b0.ready_i  : b1.ready_i;
            if (rst) begin
                mact[k] = 0; msnap[k] = 0; mw[k] = 0; ms[k] = 0;
            end else if (msnap[k]) begin
                for (int j = 0; j < 9; j++) mf[k][j] = exp_digit(dv, j);
                msnap[k] = 0; mact[k] = 1; ms[k] = 0; mw[k] = 0;
            end else if (!mact[k]) begin
                if (st) msnap[k] = 1;
            end else if (mw[k] > 0) begin
                mw[k]--;
            end else if (rd) begin
                ms[k]++;
                if (ms[k] == 9) begin
                    mact[k] = 0; msnap[k] = autok[k];
                end else begin
                    mw[k] = gapk[k];
                end
            end
        end
    end

    // ---------------- transfer logs ----------------
    logic [4:0] lg_d [64];
    int         lg_i [64];
    int         lg_c [64];
    int         nlog = 0;
    int         lg2_c [64];
    int         lg2_d [64];
    int         nlog2 = 0;

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        int  adig, aidx, avld, asof, aeof, abusy;
        int  edig, eidx, evld, esof, eeof, ebusy;
        for (int k = 0; k < 2; k++) begin
            adig  = (k == 0) ? b0.dig_o  : b1.dig_o;
            aidx  = (k == 0) ? b0.idx_o  : b1.idx_o;
            avld  = (k == 0) ? b0.vld_o  : b1.vld_o;
            asof  = (k == 0) ? b0.sof_o  : b1.sof_o;
            aeof  = (k == 0) ? b0.eof_o  : b1.eof_o;
            abusy = (k == 0) ? b0.busy_o : b1.busy_o;
            evld  = (mact[k] && mw[k] == 0) ? 1 : 0;
            edig  = evld ? int'(mf[k][ms[k]]) : 0;
            eidx  = evld ? 8 - ms[k] : 0;
            esof  = (evld && ms[k] == 0) ? 1 : 0;
            eeof  = (evld && ms[k] == 8) ? 1 : 0;
            ebusy = (mact[k] || msnap[k]) ? 1 : 0;
            chk($sformatf("vld%0d", k),  avld,  evld);
            chk($sformatf("dig%0d", k),  adig,  edig);
            chk($sformatf("idx%0d", k),  aidx,  eidx);
            chk($sformatf("sof%0d", k),  asof,  esof);
            chk($sformatf("eof%0d", k),  aeof,  eeof);
            chk($sformatf("busy%0d", k), abusy, ebusy);
        end
        if (!rst && b0.vld_o && b0.ready_i && nlog < 64) begin
            lg_d[nlog] = b0.dig_o; lg_i[nlog] = b0.idx_o; lg_c[nlog] = cyc; nlog++;
        end
        if (!rst && b1.vld_o && b1.ready_i && nlog2 < 64) begin
            lg2_d[nlog2] = b1.dig_o; lg2_c[nlog2] = cyc; nlog2++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start0(output int scyc);
        nlog = 0;
        scyc = cyc;
        b0.start_i = 1'b1;
        tick(1);
        b0.start_i = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        int n = 0;
        while (nlog < 9 && n < 200) begin tick(1); n++; end
        if (nlog < 9) chk({nm, "_timeout"}, nlog, 9);
        else tick(1);
    endtask

    task automatic check_frame(input string nm, input int e[9]);
        for (int j = 0; j < 9; j++) begin
            chk($sformatf("%s_dig%0d", nm, j), lg_d[j], e[j]);
            chk($sformatf("%s_idx%0d", nm, j), lg_i[j], 8 - j);
        end
    endtask

    task automatic wait_idx(input int ix);
        int n = 0;
        while (!(b0.vld_o && b0.idx_o == 4'(ix)) && n < 200) begin tick(1); n++; end
        if (n >= 200) chk("wait_idx_timeout", n, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int s;
        int e_sparse[9];
        int e_zero[9];
        int n0;
        b0.digits_i = '0; b0.start_i = 1'b0; b0.ready_i = 1'b0;
        b1.digits_i = '0; b1.start_i = 1'b0; b1.ready_i = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        e_sparse = '{31, 31, 31, 1, 2, 0, 3, 0, 0};
        e_zero   = '{31, 31, 31, 31, 31, 31, 31, 31, 0};
`else
        e_sparse = '{0, 0, 0, 1, 2, 0, 3, 0, 0};
        e_zero   = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        #1 rst = 1'b1;
        #2;
        chk("rst_vld", b0.vld_o, 0);
        chk("rst_busy", b0.busy_o, 0);
        chk("rst_dig", b0.dig_o, 0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Basic frame, GAP=2, ready always high.
        b0.ready_i  = 1'b1;
        b0.digits_i = pack('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        start0(s);
        wait_frame("basic");
        check_frame("basic", '{1, 2, 3, 4, 5, 6, 7, 8, 9});
        chk("basic_latency", lg_c[0] - s, 2);
        for (int j = 0; j < 8; j++) chk($sformatf("basic_spacing%0d", j), lg_c[j+1] - lg_c[j], 3);
        chk("basic_len26", lg_c[8] - s, 26);
        chk("basic_busy_drop", b0.busy_o, 0);

        // Back-pressure on idx 5.
        start0(s);
        wait_idx(5);
        b0.ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("bp_dig", b0.dig_o, 4);
            chk("bp_idx", b0.idx_o, 5);
            chk("bp_vld", b0.vld_o, 1);
        end
        n0 = nlog;
        b0.ready_i = 1'b1;
        tick(1);
        chk("bp_one_xfer", nlog - n0, 1);
        chk("bp_gap_after", b0.vld_o, 0);
        wait_frame("bp");
        check_frame("bp", '{1, 2, 3, 4, 5, 6, 7, 8, 9});

        // Snapshot isolation, plus leading-zero patterns.
        b0.digits_i = pack('{0, 0, 0, 1, 2, 0, 3, 0, 0});
        start0(s);
        tick(1);
        b0.digits_i = pack('{9, 9, 9, 9, 9, 9, 9, 9, 9});
        wait_frame("snap");
        check_frame("snap", e_sparse);
        start0(s);
        wait_frame("nines");
        check_frame("nines", '{9, 9, 9, 9, 9, 9, 9, 9, 9});
        b0.digits_i = '0;
        start0(s);
        wait_frame("zeros");
        check_frame("zeros", e_zero);
        b0.digits_i = pack('{26, 21, 16, 11, 31, 0, 17, 9, 30});
        start0(s);
        wait_frame("opaque");
        check_frame("opaque", '{26, 21, 16, 11, 31, 0, 17, 9, 30});

        // AUTO=1, GAP=0 instance with start pulses while busy.
        b1.ready_i  = 1'b1;
        b1.digits_i = pack('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        nlog2 = 0;
        s = cyc;
        b1.start_i = 1'b1;
        tick(1);
        b1.start_i = 1'b0;
        tick(6);
        b1.start_i = 1'b1;
        tick(6);
        b1.start_i = 1'b0;
        tick(20);
        chk("auto_latency", lg2_c[0] - s, 2);
        chk("auto_in_frame", lg2_c[8] - lg2_c[0], 8);
        chk("auto_period", lg2_c[9] - lg2_c[0], 10);
        chk("auto_period2", lg2_c[18] - lg2_c[9], 10);
        chk("auto_first_again", lg2_d[9], 1);
        chk("auto_last", lg2_d[17], 9);

        // Reset in the middle of a frame.
        b0.digits_i = pack('{1, 2, 3, 4, 5, 6, 7, 8, 9});
        start0(s);
        wait_idx(4);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_vld", b0.vld_o, 0);
        chk("mid_rst_dig", b0.dig_o, 0);
        chk("mid_rst_idx", b0.idx_o, 0);
        chk("mid_rst_busy", b0.busy_o, 0);
        chk("mid_rst_vld2", b1.vld_o, 0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("post_rst_vld", b0.vld_o, 0);
        chk("post_rst_busy", b0.busy_o, 0);
        chk("post_rst_busy2", b1.busy_o, 0);
        start0(s);
        wait_frame("after_rst");
        check_frame("after_rst", '{1, 2, 3, 4, 5, 6, 7, 8, 9});

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
